// File: rtl/rgb_pkg.sv
// Shared colour constants, ramp state encoding and the clamped step helper
// used by the RGB fade ramp.
package rgb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_e;

  // 24-bit {R,G,B} colours at 0x7F full scale.
  localparam logic [23:0] RED    = 24'h7F0000;
  localparam logic [23:0] YELLOW = 24'h7F7F00;
  localparam logic [23:0] GREEN  = 24'h007F00;
  localparam logic [23:0] CYAN   = 24'h007F7F;
  localparam logic [23:0] BLUE   = 24'h00007F;
  localparam logic [23:0] VIOLET = 24'h7F007F;

  // Move duty one step toward tgt; snap to tgt when within one step so the
  // result never overshoots or wraps.
  function automatic logic [7:0] step_toward(input logic [7:0] duty,
                                             input logic [7:0] tgt,
                                             input logic [7:0] step);
    logic signed [8:0] diff;
    logic [8:0]        mag;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, duty});
    mag  = diff[8] ? 9'(-diff) : 9'(diff);
    if (mag <= {1'b0, step}) begin
      return tgt;
    end else if (diff[8]) begin
      return duty - step;
    end else begin
      return duty + step;
    end
  endfunction

endpackage

// File: rtl/rgb_fade_chan.sv
// One colour channel: duty and target registers plus the clamped step.
// at_target means the next step lands exactly on the latched target.
module rgb_fade_chan
  import rgb_pkg::*;
#(
  parameter logic [7:0] STEP    = 8'd1,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       load,
  input  logic       step_en,
  input  logic [7:0] tgt_in,
  output logic [7:0] duty,
  output logic       at_target,
  output logic       load_match
);

  logic [7:0] duty_q, duty_d;
  logic [7:0] tgt_q, tgt_d;
  logic [7:0] stepped;

  always_comb begin
    stepped = step_toward(duty_q, tgt_q, STEP);
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    if (load) begin
      tgt_d = tgt_in;
    end else if (step_en) begin
      duty_d = stepped;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      duty_q <= RST_VAL;
      tgt_q  <= RST_VAL;
    end else begin
      duty_q <= duty_d;
      tgt_q  <= tgt_d;
    end
  end

  assign duty       = duty_q;
  assign at_target  = (stepped == tgt_q);
  assign load_match = (tgt_in == duty_q);

endmodule

// File: rtl/rgb_fade_ramp.sv
// Slews registered R/G/B duty outputs toward loaded targets in fixed steps
// at a prescaled rate, so PWM colour changes fade instead of snapping.
module rgb_fade_ramp
  import rgb_pkg::*;
#(
  parameter int         STEP_DIV = 100_000,
  parameter logic [7:0] STEP     = 8'd1,
  parameter logic [7:0] RST_R    = 8'h7F,
  parameter logic [7:0] RST_G    = 8'h00,
  parameter logic [7:0] RST_B    = 8'h00
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       load,
  input  logic [7:0] tgt_r,
  input  logic [7:0] tgt_g,
  input  logic [7:0] tgt_b,
  output logic [7:0] duty_r,
  output logic [7:0] duty_g,
  output logic [7:0] duty_b,
  output logic       busy,
  output logic       done
);

  localparam logic [23:0] PRESC_MAX = 24'(STEP_DIV - 1);

  ramp_state_e state_q, state_d;
  logic [23:0] presc_q, presc_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        step_en;
  logic [2:0]  at_target;
  logic [2:0]  load_match;

  rgb_fade_chan #(.STEP(STEP), .RST_VAL(RST_R)) u_chan_r (
    .clk(clk), .nrst(nrst), .load(load), .step_en(step_en), .tgt_in(tgt_r),
    .duty(duty_r), .at_target(at_target[2]), .load_match(load_match[2])
  );

  rgb_fade_chan #(.STEP(STEP), .RST_VAL(RST_G)) u_chan_g (
    .clk(clk), .nrst(nrst), .load(load), .step_en(step_en), .tgt_in(tgt_g),
    .duty(duty_g), .at_target(at_target[1]), .load_match(load_match[1])
  );

  rgb_fade_chan #(.STEP(STEP), .RST_VAL(RST_B)) u_chan_b (
    .clk(clk), .nrst(nrst), .load(load), .step_en(step_en), .tgt_in(tgt_b),
    .duty(duty_b), .at_target(at_target[0]), .load_match(load_match[0])
  );

  // A load always takes priority over a step falling on the same edge.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    step_en = 1'b0;
    case (state_q)
      IDLE: begin
        presc_d = '0;
        if (load) begin
          if (&load_match) begin
            done_d = 1'b1;
          end else begin
            state_d = RAMP;
            busy_d  = 1'b1;
          end
        end
      end
      RAMP: begin
        if (load) begin
          presc_d = '0;
          if (&load_match) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          step_en = 1'b1;
          if (&at_target) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          presc_d = presc_q + 24'd1;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      presc_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
